// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash ID responder: command codes, FSM states
// and the identification byte sequences it can play back.
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ_ID    = 8'h90;
  localparam logic [7:0] CMD_JEDEC_ID   = 8'h9F;
  localparam logic [7:0] CMD_RELEASE_PD = 8'hAB;

  localparam logic [4:0] CMD_BITS  = 5'd8;
  localparam logic [4:0] ADDR_BITS = 5'd24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_IGNORE
  } state_e;

  typedef enum logic [1:0] {
    SEQ_MF_DEV,
    SEQ_DEV_MF,
    SEQ_JEDEC,
    SEQ_DEV
  } seq_e;

  function automatic logic [1:0] seq_len(seq_e s);
    case (s)
      SEQ_MF_DEV, SEQ_DEV_MF: seq_len = 2'd2;
      SEQ_JEDEC:              seq_len = 2'd3;
      default:                seq_len = 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Synchronizes SS, SCK and MOSI into the clk domain and detects SCK edges.
// primed rises once the chains hold only genuinely sampled pin values.
module spi_in_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic spi_ss,
  input  logic spi_sck,
  input  logic spi_mosi,
  output logic ss_n,
  output logic mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic primed
);

  logic [STAGES-1:0] ss_sync;
  logic [STAGES-1:0] sck_sync;
  logic [STAGES-1:0] mosi_sync;
  logic [STAGES-1:0] prime_sync;
  logic              sck_prev;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: SS resets to the deasserted level so a reset never looks like a selected bus.
      ss_sync    <= '1;
      sck_sync   <= '0;
      mosi_sync  <= '0;
      prime_sync <= '0;
      sck_prev   <= 1'b0;
    end else begin
      ss_sync    <= {ss_sync[STAGES-2:0], spi_ss};
      sck_sync   <= {sck_sync[STAGES-2:0], spi_sck};
      mosi_sync  <= {mosi_sync[STAGES-2:0], spi_mosi};
      prime_sync <= {prime_sync[STAGES-2:0], 1'b1};
      sck_prev   <= sck_sync[STAGES-1];
    end
  end

  assign ss_n     = ss_sync[STAGES-1];
  assign mosi     = mosi_sync[STAGES-1];
  assign sck_rise = sck_sync[STAGES-1] & ~sck_prev;
  assign sck_fall = ~sck_sync[STAGES-1] & sck_prev;
  assign primed   = prime_sync[STAGES-1];

endmodule

// File: rtl/spi_flash_id_responder.sv
// SPI mode-0 responder emulating W25Q identification commands (90h, ABh, 9Fh).
// Define SPI_FLASH_RESP_JEDEC_EN to decode 9Fh; otherwise it is ignored.
module spi_flash_id_responder
  import spi_flash_pkg::*;
#(
  parameter logic [7:0] MF_ID       = 8'hEF,
  parameter logic [7:0] DEV_ID      = 8'h17,
  parameter logic [7:0] JEDEC_TYPE  = 8'h40,
  parameter logic [7:0] JEDEC_CAP   = 8'h18,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       spi_ss,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic       busy
);

  logic ss_n;
  logic mosi;
  logic sck_rise;
  logic sck_fall;
  logic primed;

  spi_in_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rstn    (rstn),
    .spi_ss  (spi_ss),
    .spi_sck (spi_sck),
    .spi_mosi(spi_mosi),
    .ss_n    (ss_n),
    .mosi    (mosi),
    .sck_rise(sck_rise),
    .sck_fall(sck_fall),
    .primed  (primed)
  );

  state_e     state, state_next;
  seq_e       seq, seq_next;
  logic [4:0] bit_cnt, bit_cnt_next;
  logic [1:0] byte_idx, byte_idx_next;
  logic [7:0] cmd_shift, cmd_shift_next;
  logic [7:0] cmd_code_q, cmd_code_next;
  logic       cmd_valid_q, cmd_valid_next;
  logic       miso_q, miso_next;
  logic       oe_q, oe_next;
  logic       armed, armed_next;

  function automatic logic [7:0] seq_byte(seq_e s, logic [1:0] idx);
    case (s)
      SEQ_MF_DEV: seq_byte = (idx == 2'd0) ? MF_ID : DEV_ID;
      SEQ_DEV_MF: seq_byte = (idx == 2'd0) ? DEV_ID : MF_ID;
      SEQ_JEDEC: begin
        case (idx)
          2'd0:    seq_byte = MF_ID;
          2'd1:    seq_byte = JEDEC_TYPE;
          default: seq_byte = JEDEC_CAP;
        endcase
      end
      default:    seq_byte = DEV_ID;
    endcase
  endfunction

  logic [7:0] first_byte;
  logic [7:0] cur_byte;
  logic [7:0] nxt_byte;
  logic [1:0] idx_wrap;
  logic [4:0] cnt_inc;
  logic [7:0] cmd_byte;
  logic       enter_data;

  always_comb begin
    first_byte = seq_byte(seq, 2'd0);
    idx_wrap   = (byte_idx + 2'd1 == seq_len(seq)) ? 2'd0 : byte_idx + 2'd1;
    cur_byte   = seq_byte(seq, byte_idx);
    nxt_byte   = seq_byte(seq, idx_wrap);
    cnt_inc    = bit_cnt + 5'd1;
    cmd_byte   = {cmd_shift[6:0], mosi};

    // NOTE: every variable gets a default first so no path can infer a latch.
    state_next     = state;
    seq_next       = seq;
    bit_cnt_next   = bit_cnt;
    byte_idx_next  = byte_idx;
    cmd_shift_next = cmd_shift;
    cmd_code_next  = cmd_code_q;
    cmd_valid_next = 1'b0;
    miso_next      = miso_q;
    oe_next        = oe_q;
    armed_next     = armed | (primed & ss_n);
    enter_data     = 1'b0;

    if (ss_n) begin
      state_next    = ST_IDLE;
      bit_cnt_next  = '0;
      byte_idx_next = '0;
      miso_next     = 1'b0;
      oe_next       = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (armed) begin
            state_next   = ST_CMD;
            bit_cnt_next = '0;
          end
        end

        ST_CMD: begin
          if (sck_rise && bit_cnt < CMD_BITS) begin
            cmd_shift_next = cmd_byte;
            bit_cnt_next   = cnt_inc;
            if (cnt_inc == CMD_BITS) begin
              cmd_code_next  = cmd_byte;
              cmd_valid_next = 1'b1;
              bit_cnt_next   = '0;
              case (cmd_byte)
                CMD_READ_ID:    state_next = ST_ADDR;
                CMD_RELEASE_PD: begin
                  state_next = ST_DUMMY;
                  seq_next   = SEQ_DEV;
                end
`ifdef SPI_FLASH_RESP_JEDEC_EN
                CMD_JEDEC_ID: begin
                  // Hold at 8 until the closing SCK fall hands over to DATA.
                  bit_cnt_next = CMD_BITS;
                  seq_next     = SEQ_JEDEC;
                end
`endif
                default:        state_next = ST_IGNORE;
              endcase
            end
          end else if (sck_fall && bit_cnt == CMD_BITS) begin
            enter_data = 1'b1;
          end
        end

        ST_ADDR: begin
          if (sck_rise && bit_cnt < ADDR_BITS) begin
            bit_cnt_next = cnt_inc;
            if (cnt_inc == ADDR_BITS) begin
              seq_next = mosi ? SEQ_DEV_MF : SEQ_MF_DEV;
            end
          end else if (sck_fall && bit_cnt == ADDR_BITS) begin
            enter_data = 1'b1;
          end
        end

        ST_DUMMY: begin
          if (sck_rise && bit_cnt < ADDR_BITS) begin
            bit_cnt_next = cnt_inc;
          end else if (sck_fall && bit_cnt == ADDR_BITS) begin
            enter_data = 1'b1;
          end
        end

        ST_DATA: begin
          if (sck_fall) begin
            if (cnt_inc == CMD_BITS) begin
              bit_cnt_next  = '0;
              byte_idx_next = idx_wrap;
              miso_next     = nxt_byte[7];
            end else begin
              bit_cnt_next = cnt_inc;
              miso_next    = cur_byte[3'(5'd7 - cnt_inc)];
            end
          end
        end

        default: begin
          oe_next = 1'b0;
        end
      endcase

      if (enter_data) begin
        state_next    = ST_DATA;
        bit_cnt_next  = '0;
        byte_idx_next = '0;
        miso_next     = first_byte[7];
        oe_next       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      seq         <= SEQ_DEV;
      bit_cnt     <= '0;
      byte_idx    <= '0;
      cmd_shift   <= '0;
      cmd_code_q  <= '0;
      cmd_valid_q <= 1'b0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      armed       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers update together.
      state       <= state_next;
      seq         <= seq_next;
      bit_cnt     <= bit_cnt_next;
      byte_idx    <= byte_idx_next;
      cmd_shift   <= cmd_shift_next;
      cmd_code_q  <= cmd_code_next;
      cmd_valid_q <= cmd_valid_next;
      miso_q      <= miso_next;
      oe_q        <= oe_next;
      armed       <= armed_next;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_code    = cmd_code_q;
  assign busy        = ~ss_n;

endmodule

// File: tb/tb_spi_flash_id_responder.sv
// Scoreboard bench for spi_flash_id_responder: expected ID bytes are queued as
// each transaction is issued and popped as the SPI master captures MISO.
module tb_spi_flash_id_responder;

  localparam int SYNC = 2;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       spi_ss = 1'b1;
  logic       spi_sck = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic       busy;

  spi_flash_id_responder #(
    .MF_ID      (8'hEF),
    .DEV_ID     (8'h17),
    .JEDEC_TYPE (8'h40),
    .JEDEC_CAP  (8'h18),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .spi_ss     (spi_ss),
    .spi_sck    (spi_sck),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int valid_cnt = 0;
  int valid_cyc = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (cmd_valid) begin
      valid_cnt++;
      valid_cyc = cyc;
    end
  end

  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] sb[$];
  logic [7:0] rx_q[$];
  logic       pre_oe_any;
  logic       data_oe_all;
  logic       data_oe_any;
  int         last_rise_cyc;
  int         cmd_rise_cyc;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode-0 master: MOSI set while SCK low, MISO sampled just before the rise.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx,
                          output logic oe_all, output logic oe_any);
    rx = '0;
    oe_all = 1'b1;
    oe_any = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[3'(7 - i)];
      wait_clk(HALF);
      rx = {rx[6:0], spi_miso};
      oe_all = oe_all & spi_miso_oe;
      oe_any = oe_any | spi_miso_oe;
      spi_sck = 1'b1;
      last_rise_cyc = cyc;
      wait_clk(HALF);
      spi_sck = 1'b0;
    end
  endtask

  task automatic run_xfer(input logic [7:0] cmd, input logic [23:0] addr, input int n_addr,
                          input int n_read);
    logic [7:0] rx;
    logic       oa, on;
    rx_q.delete();
    pre_oe_any = 1'b0;
    data_oe_all = 1'b1;
    data_oe_any = 1'b0;
    spi_ss = 1'b0;
    wait_clk(HALF);
    spi_bits(cmd, 8, rx, oa, on);
    pre_oe_any |= on;
    cmd_rise_cyc = last_rise_cyc;
    for (int i = 0; i < n_addr; i++) begin
      spi_bits(addr[8*(2-i) +: 8], 8, rx, oa, on);
      pre_oe_any |= on;
    end
    for (int i = 0; i < n_read; i++) begin
      spi_bits(8'h00, 8, rx, oa, on);
      rx_q.push_back(rx);
      data_oe_all &= oa;
      data_oe_any |= on;
    end
    spi_ss = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    wait_clk(3);
    n_checks++; if (spi_miso !== 1'b0) $display("FAIL reset_miso got=%b exp=0", spi_miso); else n_pass++;
    n_checks++; if (spi_miso_oe !== 1'b0) $display("FAIL reset_oe got=%b exp=0", spi_miso_oe); else n_pass++;
    n_checks++; if (cmd_valid !== 1'b0) $display("FAIL reset_cmd_valid got=%b exp=0", cmd_valid); else n_pass++;
    n_checks++; if (cmd_code !== 8'h00) $display("FAIL reset_cmd_code got=%h exp=00", cmd_code); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    rstn = 1'b1;
    wait_clk(10);
  endtask

  task automatic test_read_id(input logic [23:0] addr, input int n_read);
    logic [7:0] exp;
    int         base;
    base = valid_cnt;
    for (int i = 0; i < n_read; i++) sb.push_back(((i % 2 == 0) ^ addr[0]) ? 8'hEF : 8'h17);
    run_xfer(8'h90, addr, 3, n_read);
    foreach (rx_q[i]) begin
      exp = sb.pop_front();
      n_checks++;
      if (rx_q[i] !== exp) $display("FAIL read_id_a%0h_b%0d got=%h exp=%h", addr, i, rx_q[i], exp);
      else n_pass++;
    end
    n_checks++; if (pre_oe_any !== 1'b0) $display("FAIL read_id_pre_oe got=%b exp=0", pre_oe_any); else n_pass++;
    n_checks++; if (data_oe_all !== 1'b1) $display("FAIL read_id_data_oe got=%b exp=1", data_oe_all); else n_pass++;
    n_checks++; if (valid_cnt - base !== 1) $display("FAIL read_id_valid_pulses got=%0d exp=1", valid_cnt - base); else n_pass++;
    n_checks++; if (cmd_code !== 8'h90) $display("FAIL read_id_cmd_code got=%h exp=90", cmd_code); else n_pass++;
    n_checks++;
    if (valid_cyc - cmd_rise_cyc !== SYNC + 1)
      $display("FAIL cmd_valid_latency got=%0d exp=%0d", valid_cyc - cmd_rise_cyc, SYNC + 1);
    else n_pass++;
  endtask

  task automatic test_jedec;
    logic [7:0] exp;
`ifdef SPI_FLASH_RESP_JEDEC_EN
    sb.push_back(8'hEF); sb.push_back(8'h40); sb.push_back(8'h18); sb.push_back(8'hEF);
    run_xfer(8'h9F, 24'h0, 0, 4);
    foreach (rx_q[i]) begin
      exp = sb.pop_front();
      n_checks++;
      if (rx_q[i] !== exp) $display("FAIL jedec_b%0d got=%h exp=%h", i, rx_q[i], exp);
      else n_pass++;
    end
    n_checks++; if (data_oe_all !== 1'b1) $display("FAIL jedec_oe got=%b exp=1", data_oe_all); else n_pass++;
`else
    exp = 8'h00;
    run_xfer(8'h9F, 24'h0, 0, 4);
    n_checks++; if (data_oe_any !== exp[0]) $display("FAIL jedec_ignored_oe got=%b exp=0", data_oe_any); else n_pass++;
`endif
    n_checks++; if (cmd_code !== 8'h9F) $display("FAIL jedec_cmd_code got=%h exp=9F", cmd_code); else n_pass++;
  endtask

  task automatic test_release_pd;
    logic [7:0] exp;
    sb.push_back(8'h17); sb.push_back(8'h17);
    run_xfer(8'hAB, 24'hA5A5A5, 3, 2);
    foreach (rx_q[i]) begin
      exp = sb.pop_front();
      n_checks++;
      if (rx_q[i] !== exp) $display("FAIL release_pd_b%0d got=%h exp=%h", i, rx_q[i], exp);
      else n_pass++;
    end
    n_checks++; if (data_oe_all !== 1'b1) $display("FAIL release_pd_oe got=%b exp=1", data_oe_all); else n_pass++;
    n_checks++; if (cmd_code !== 8'hAB) $display("FAIL release_pd_cmd_code got=%h exp=AB", cmd_code); else n_pass++;
  endtask

  task automatic test_abort;
    logic [7:0] rx;
    logic       oa, on;
    // Abort after 13 bits (command plus 5 address bits).
    spi_ss = 1'b0;
    wait_clk(HALF);
    spi_bits(8'h90, 8, rx, oa, on);
    spi_bits(8'h00, 5, rx, oa, on);
    spi_ss = 1'b1;
    wait_clk(SYNC + 1);
    n_checks++; if (spi_miso_oe !== 1'b0) $display("FAIL abort13_oe got=%b exp=0", spi_miso_oe); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort13_busy got=%b exp=0", busy); else n_pass++;
    wait_clk(2 * HALF);
    // Abort mid-byte in DATA: the driver must release MISO within SYNC+1 clk.
    spi_ss = 1'b0;
    wait_clk(HALF);
    spi_bits(8'h90, 8, rx, oa, on);
    for (int i = 0; i < 3; i++) spi_bits(8'h00, 8, rx, oa, on);
    spi_bits(8'h00, 3, rx, oa, on);
    n_checks++; if (spi_miso_oe !== 1'b1) $display("FAIL abort_data_pre_oe got=%b exp=1", spi_miso_oe); else n_pass++;
    spi_ss = 1'b1;
    wait_clk(SYNC + 1);
    n_checks++; if (spi_miso_oe !== 1'b0) $display("FAIL abort_data_oe got=%b exp=0", spi_miso_oe); else n_pass++;
    wait_clk(2 * HALF);
    test_read_id(24'h000000, 2);
  endtask

  task automatic test_reset_mid;
    logic [7:0] rx;
    logic       oa, on;
    logic [7:0] exp;
    int         base;
    sb.push_back(8'hEF);
    spi_ss = 1'b0;
    wait_clk(HALF);
    spi_bits(8'h90, 8, rx, oa, on);
    for (int i = 0; i < 3; i++) spi_bits(8'h00, 8, rx, oa, on);
    spi_bits(8'h00, 8, rx, oa, on);
    exp = sb.pop_front();
    n_checks++; if (rx !== exp) $display("FAIL rst_mid_first got=%h exp=%h", rx, exp); else n_pass++;
    spi_bits(8'h00, 3, rx, oa, on);
    n_checks++; if (spi_miso_oe !== 1'b1) $display("FAIL rst_mid_pre_oe got=%b exp=1", spi_miso_oe); else n_pass++;
    rstn = 1'b0;
    #1;
    n_checks++; if (spi_miso !== 1'b0) $display("FAIL rst_mid_miso got=%b exp=0", spi_miso); else n_pass++;
    n_checks++; if (spi_miso_oe !== 1'b0) $display("FAIL rst_mid_oe got=%b exp=0", spi_miso_oe); else n_pass++;
    n_checks++; if (cmd_valid !== 1'b0) $display("FAIL rst_mid_cmd_valid got=%b exp=0", cmd_valid); else n_pass++;
    n_checks++; if (cmd_code !== 8'h00) $display("FAIL rst_mid_cmd_code got=%h exp=00", cmd_code); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got=%b exp=0", busy); else n_pass++;
    wait_clk(2);
    rstn = 1'b1;
    base = valid_cnt;
    // Remainder of the interrupted frame, with SS still low, must be ignored.
    spi_bits(8'h90, 8, rx, oa, on);
    pre_oe_any = on;
    spi_bits(8'h00, 8, rx, oa, on);
    pre_oe_any |= on;
    n_checks++; if (pre_oe_any !== 1'b0) $display("FAIL rst_mid_ignored_oe got=%b exp=0", pre_oe_any); else n_pass++;
    n_checks++; if (valid_cnt - base !== 0) $display("FAIL rst_mid_ignored_valid got=%0d exp=0", valid_cnt - base); else n_pass++;
    spi_ss = 1'b1;
    wait_clk(2 * HALF);
    test_read_id(24'h000000, 2);
  endtask

  initial begin
    test_reset;
    test_read_id(24'h000000, 2);
    test_read_id(24'h000001, 3);
    test_jedec;
    test_release_pd;
    test_abort;
    test_reset_mid;
    n_checks++;
    if (sb.size() !== 0) $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
